// File: rtl/w2r_sync_level.sv
// ---------------------------------------------------------------------------
// w2r_sync_level
//
// Brings the Gray-coded write pointer of an async FIFO into the read clock
// domain. It then derives a registered read-side occupancy, an almost-empty
// flag, and two sticky error flags.
//
// Parameters
//   ADDRSIZE     FIFO address width; pointers are ADDRSIZE+1 bits
//   SYNC_STAGES  synchronizer depth in rclk flops (minimum 2)
//   AE_THRESH    almost-empty threshold in entries
//
// Ports
//   rclk           in   read-domain clock, rising edge
//   rrst_n         in   async active-low reset (release synchronized upstream)
//   wptr_gray      in   write pointer, Gray, from the write clock domain
//   rptr_bina      in   read pointer, binary, rclk domain
//   r_en           in   read request
//   rempty         in   empty flag from the read-side logic
//   rerr_clr       in   synchronous clear of the sticky error flags
//   w2rptr         out  synchronized write pointer, Gray
//   rlevel         out  registered occupancy, modulo 2^(ADDRSIZE+1)
//   ralmost_empty  out  registered, high when occupancy <= AE_THRESH
//   runderflow     out  sticky, a read was attempted while empty
//   rgray_err      out  sticky, the synchronized pointer moved by more than
//                       one bit in a single cycle
//
// Build option
//   W2R_GRAY_CHECK_EN  when defined, enables the Gray-step checker behind
//                      rgray_err. Otherwise rgray_err is tied to 0 and the
//                      port list is the same.
// ---------------------------------------------------------------------------
module w2r_sync_level #(
  parameter int ADDRSIZE    = 7,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr_gray,
  input  logic [ADDRSIZE:0]   rptr_bina,
  input  logic                r_en,
  input  logic                rempty,
  input  logic                rerr_clr,
  output logic [ADDRSIZE:0]   w2rptr,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                ralmost_empty,
  output logic                runderflow,
  output logic                rgray_err
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain flop chain. No logic sits between the stages, so each stage has
  // the full period to resolve metastability.
  logic [PW-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign w2rptr = sync_q[SYNC_STAGES-1];

  // Occupancy. Pointer wrap is covered by the modular subtraction alone.
  // The result is intentionally not saturated.
  logic [PW-1:0] w2r_bin;
  logic [PW-1:0] level_d;
  logic          ae_d;

  always_comb begin
    w2r_bin = gray2bin(w2rptr);
    level_d = w2r_bin - rptr_bina;
    ae_d    = (level_d <= AE_LIM);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
    end else begin
      rlevel        <= level_d;
      ralmost_empty <= ae_d;
    end
  end

  // Sticky flags: when set and clear occur in the same cycle, set wins.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      runderflow <= 1'b0;
    end else if (r_en && rempty) begin
      runderflow <= 1'b1;
    end else if (rerr_clr) begin
      runderflow <= 1'b0;
    end
  end

`ifdef W2R_GRAY_CHECK_EN
  logic [PW-1:0] prev_q;
  logic [PW-1:0] gray_diff;
  logic          multi_bit;

  // More than one bit changed when clearing the lowest set bit of the
  // difference still leaves some bit set.
  always_comb begin
    gray_diff = w2rptr ^ prev_q;
    multi_bit = |(gray_diff & (gray_diff - PW'(1)));
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      prev_q    <= '0;
      rgray_err <= 1'b0;
    end else begin
      prev_q <= w2rptr;
      if (multi_bit) begin
        rgray_err <= 1'b1;
      end else if (rerr_clr) begin
        rgray_err <= 1'b0;
      end
    end
  end
`else
  assign rgray_err = 1'b0;
`endif

endmodule
